// File: rtl/sm_1118_uart_msg_scheduler_pkg.sv
// Shared definitions for the UART message scheduler.
// Contents: message-type codes, ASCII constants, FSM state encoding,
// the 8-bit packed message tuple, and helpers that map a tuple to its
// byte string (byte lookup, last byte index, drop test).
package sm_1118_uart_msg_scheduler_pkg;

    localparam logic [1:0] MSG_NONE = 2'd0;
    localparam logic [1:0] MSG_SI   = 2'd1;
    localparam logic [1:0] MSG_FARM = 2'd2;
    localparam logic [1:0] MSG_END  = 2'd3;

    localparam logic [7:0] ASC_S     = 8'h53;
    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_F     = 8'h46;
    localparam logic [7:0] ASC_E     = 8'h45;
    localparam logic [7:0] ASC_N     = 8'h4E;
    localparam logic [7:0] ASC_D     = 8'h44;
    localparam logic [7:0] ASC_R     = 8'h52;
    localparam logic [7:0] ASC_G     = 8'h47;
    localparam logic [7:0] ASC_B     = 8'h42;
    localparam logic [7:0] ASC_DASH  = 8'h2D;
    localparam logic [7:0] ASC_HASH  = 8'h23;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_e;

    // Packed tuple, MSB first: msgtype, sino, color, farm (2 bits each).
    typedef struct packed {
        logic [1:0] msgtype;
        logic [1:0] sino;
        logic [1:0] color;
        logic [1:0] farm;
    } msg_t;

    function automatic logic [7:0] color_char(input logic [1:0] c);
        case (c)
            2'd1:    return ASC_R;
            2'd2:    return ASC_G;
            default: return ASC_B;
        endcase
    endfunction

    function automatic logic [7:0] digit_char(input logic [1:0] d);
        return ASC_ZERO + {6'd0, d};
    endfunction

    // Byte idx of the ASCII string for message m.
    function automatic logic [7:0] msg_byte(input msg_t m, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (m.msgtype)
            MSG_SI: begin
                case (idx)
                    3'd0: b = ASC_S;
                    3'd1: b = ASC_I;
                    3'd3: b = digit_char(m.sino);
                    3'd5: b = color_char(m.color);
                    3'd7: b = ASC_HASH;
                    default: b = ASC_DASH;
                endcase
            end
            MSG_FARM: begin
                case (idx)
                    3'd0: b = ASC_F;
                    3'd2: b = digit_char(m.farm);
                    3'd4: b = ASC_HASH;
                    default: b = ASC_DASH;
                endcase
            end
            MSG_END: begin
                case (idx)
                    3'd0: b = ASC_E;
                    3'd1: b = ASC_N;
                    3'd2: b = ASC_D;
                    3'd3: b = ASC_DASH;
                    default: b = ASC_HASH;
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Index of the final byte: SI is 8 bytes long, FARM/END are 5.
    function automatic logic [2:0] msg_last_idx(input logic [1:0] t);
        return (t == MSG_SI) ? 3'd7 : 3'd4;
    endfunction

    // Tuples that complete a handshake but never enter the queue.
    function automatic logic msg_invalid(input msg_t m);
        return (m.msgtype == MSG_NONE) ||
               ((m.msgtype == MSG_SI) && ((m.sino == 2'd0) || (m.color == 2'd0)));
    endfunction

endpackage

// File: rtl/sm_1118_uart_msg_scheduler_fifo.sv
// Synchronous FIFO holding packed message tuples.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the queue)
//   push_i/wdata_i  write strobe and data (ignored when full)
//   pop_i/rdata_o   read strobe (ignored when empty); rdata_o shows the head
//   full_o/empty_o  status flags
//   count_o         number of entries held (0..DEPTH)
module sm_1118_uart_msg_scheduler_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sm_1118_uart_msg_scheduler.sv
// UART message scheduler: two requesters share one byte transmitter.
// Requests are arbitrated round-robin, de-duplicated per requester, queued,
// then serialised one ASCII byte at a time with a per-byte timeout.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rN_valid/rN_ready           requester handshake (N = 0,1)
//   rN_msgtype/sino/color/farm  message tuple fields
//   tx_start/tx_data/tx_done    byte interface to the UART TX core
//   busy                        serialisation in progress
//   fifo_count                  queued messages
//   err_timeout                 sticky byte-timeout flag
module sm_1118_uart_msg_scheduler
    import sm_1118_uart_msg_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TX_TIMEOUT = 20000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          r0_valid,
    output logic                          r0_ready,
    input  logic [1:0]                    r0_msgtype,
    input  logic [1:0]                    r0_sino,
    input  logic [1:0]                    r0_color,
    input  logic [1:0]                    r0_farm,
    input  logic                          r1_valid,
    output logic                          r1_ready,
    input  logic [1:0]                    r1_msgtype,
    input  logic [1:0]                    r1_sino,
    input  logic [1:0]                    r1_color,
    input  logic [1:0]                    r1_farm,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    input  logic                          tx_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_timeout
);

    localparam int TW = $clog2(TX_TIMEOUT);

    // ---------------- arbitration and dedup ----------------
    msg_t   req0, req1, acc_msg, acc_last;
    msg_t   last0_q, last0_d, last1_q, last1_d;
    logic   rr_q, rr_d;          // 0: r0 wins a tie, 1: r1 wins
    logic   hs0, hs1, push;
    logic   fifo_full, fifo_empty;
    logic   pop;
    logic [7:0] fifo_rdata;
    msg_t   head;

    assign req0 = '{msgtype: r0_msgtype, sino: r0_sino, color: r0_color, farm: r0_farm};
    assign req1 = '{msgtype: r1_msgtype, sino: r1_sino, color: r1_color, farm: r1_farm};
    assign head = msg_t'(fifo_rdata);

    // Ready looks at full only, so a pop in the same cycle never frees a slot early.
    assign r0_ready = !fifo_full && r0_valid && (!r1_valid || !rr_q);
    assign r1_ready = !fifo_full && r1_valid && (!r0_valid ||  rr_q);
    assign hs0 = r0_valid && r0_ready;
    assign hs1 = r1_valid && r1_ready;

    always_comb begin
        acc_msg  = hs0 ? req0 : req1;
        acc_last = hs0 ? last0_q : last1_q;
        push     = (hs0 || hs1) && !msg_invalid(acc_msg) && (acc_msg != acc_last);
        last0_d  = last0_q;
        last1_d  = last1_q;
        if (push && hs0) last0_d = req0;
        if (push && hs1) last1_d = req1;
        rr_d = rr_q;
        if (hs0)      rr_d = 1'b1;
        else if (hs1) rr_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= 1'b0;
            last0_q <= '0;
            last1_q <= '0;
        end else begin
            rr_q    <= rr_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end

    sm_1118_uart_msg_scheduler_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (acc_msg),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------- serialiser FSM ----------------
    state_e          state_q, state_d;
    msg_t            msg_q, msg_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      last_idx_q, last_idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            err_q, err_d;

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        err_d      = err_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop        = 1'b1;
                msg_d      = head;
                idx_d      = 3'd0;
                last_idx_d = msg_last_idx(head.msgtype);
                // Byte is registered on entry to SEND so it is stable with tx_start.
                tx_data_d  = msg_byte(head, 3'd0);
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // tx_done has priority over a timeout landing in the same cycle.
                if (tx_done) begin
                    if (idx_q == last_idx_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = msg_byte(msg_q, idx_q + 3'd1);
                        state_d   = ST_SEND;
                    end
                end else if (timer_q == TW'(TX_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    msg_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            msg_q      <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            timer_q    <= '0;
            tx_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            timer_q    <= timer_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end

    assign tx_start    = (state_q == ST_SEND);
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sm_1118_uart_msg_scheduler.sv
module tb_sm_1118_uart_msg_scheduler;

    localparam int DEPTH = 4;
    localparam int TO    = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0_valid = 1'b0, r1_valid = 1'b0;
    logic       r0_ready, r1_ready;
    logic [1:0] r0_msgtype = '0, r0_sino = '0, r0_color = '0, r0_farm = '0;
    logic [1:0] r1_msgtype = '0, r1_sino = '0, r1_color = '0, r1_farm = '0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       busy;
    logic [2:0] fifo_count;
    logic       err_timeout;

    sm_1118_uart_msg_scheduler #(.FIFO_DEPTH(DEPTH), .TX_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_msgtype(r0_msgtype),
        .r0_sino(r0_sino), .r0_color(r0_color), .r0_farm(r0_farm),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_msgtype(r1_msgtype),
        .r1_sino(r1_sino), .r1_color(r1_color), .r1_farm(r1_farm),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .fifo_count(fifo_count), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];          // expected bytes, in transmit order
    logic [7:0] last_t[2];      // model of last pushed tuple per requester
    int         done_delay = 3;
    bit         stall = 0;
    bit         stall_en = 0;
    logic [7:0] stall_val = 8'h00;
    bit         pend = 0;
    int         cnt = 0;
    logic [7:0] exp_b;
    int         peak = 0;

    // UART model plus byte scoreboard, both sampled on the falling edge.
    always @(negedge clk) begin
        if (fifo_count > peak) peak = fifo_count;
        if (!rst_n) begin
            pend    = 0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_start) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: unexpected tx_start with data %h, none expected", tx_data);
                end else begin
                    exp_b = sb.pop_front();
                    if (tx_data !== exp_b) begin
                        errors++;
                        $display("FAIL tx_byte: got %h expected %h", tx_data, exp_b);
                    end
                end
                if (!(stall_en && tx_data == stall_val)) begin
                    pend = 1;
                    cnt  = done_delay;
                end
            end else if (pend && !stall) begin
                if (cnt <= 1) begin
                    tx_done = 1'b1;
                    pend    = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    function automatic string msg_str(input logic [1:0] mt, sn, cl, fm);
        string c;
        c = (cl == 2'd1) ? "R" : (cl == 2'd2) ? "G" : "B";
        case (mt)
            2'd1:    return $sformatf("SI-%0d-%s-#", sn, c);
            2'd2:    return $sformatf("F-%0d-#", fm);
            2'd3:    return "END-#";
            default: return "";
        endcase
    endfunction

    task automatic model_accept(input int r, input logic [1:0] mt, sn, cl, fm, input int nb);
        logic [7:0] t;
        string s;
        t = {mt, sn, cl, fm};
        if (mt == 2'd0 || (mt == 2'd1 && (sn == 2'd0 || cl == 2'd0)) || t == last_t[r]) return;
        last_t[r] = t;
        s = msg_str(mt, sn, cl, fm);
        for (int i = 0; i < s.len(); i++)
            if (nb < 0 || i < nb) sb.push_back(s[i]);
    endtask

    task automatic drive(input int r, input logic v, input logic [1:0] mt, sn, cl, fm);
        if (r == 0) begin
            r0_valid = v; r0_msgtype = mt; r0_sino = sn; r0_color = cl; r0_farm = fm;
        end else begin
            r1_valid = v; r1_msgtype = mt; r1_sino = sn; r1_color = cl; r1_farm = fm;
        end
    endtask

    // Present a request, wait for ready (bounded), complete the handshake.
    task automatic send(input int r, input logic [1:0] mt, sn, cl, fm, input int nb, output int waited);
        int n = 0;
        drive(r, 1'b1, mt, sn, cl, fm);
        #1;
        while (!((r == 0) ? r0_ready : r1_ready) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        waited = n;
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL send_ready: r%0d ready stayed %b, required 1", r, 1'b0);
            drive(r, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
            return;
        end
        @(posedge clk);
        model_accept(r, mt, sn, cl, fm, nb);
        #1;
        drive(r, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (n < budget && !(sb.size() == 0 && !busy && fifo_count == 0 && !pend)) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still expected, busy=%b count=%0d, required 0/0/0",
                     name, sb.size(), busy, fifo_count);
        end
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        drive(1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        rst_n = 1'b0;
        sb.delete();
        last_t[0] = '0; last_t[1] = '0;
        stall = 0; stall_en = 0; done_delay = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({tx_start, tx_data, busy, fifo_count, err_timeout, r0_ready, r1_ready} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b data=%h busy=%b count=%0d err=%b rdy=%b%b, required all 0",
                     tx_start, tx_data, busy, fifo_count, err_timeout, r0_ready, r1_ready);
        end
        do_reset();
    endtask

    task automatic test_single_si();
        int w;
        done_delay = 100;
        send(0, 2'd1, 2'd2, 2'd1, 2'd0, -1, w);
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b0) begin
            errors++; $display("FAIL latency_early: tx_start=%b at push+2, required 0", tx_start);
        end
        @(posedge clk); #1;
        checks++;
        if (tx_start !== 1'b1) begin
            errors++; $display("FAIL latency: tx_start=%b at push+3, required 1", tx_start);
        end
        wait_idle(3000, "single_si");
        done_delay = 3;
    endtask

    task automatic test_arbitration();
        do_reset();
        drive(0, 1'b1, 2'd1, 2'd1, 2'd2, 2'd0);
        drive(1, 1'b1, 2'd3, 2'd0, 2'd0, 2'd0);
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b10) begin
            errors++; $display("FAIL arb_first: ready r0r1=%b, required 10", {r0_ready, r1_ready});
        end
        @(posedge clk);
        model_accept(0, 2'd1, 2'd1, 2'd2, 2'd0, -1);
        #1;
        drive(0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        #1;
        checks++;
        if (r1_ready !== 1'b1) begin
            errors++; $display("FAIL arb_second: r1_ready=%b, required 1", r1_ready);
        end
        @(posedge clk);
        model_accept(1, 2'd3, 2'd0, 2'd0, 2'd0, -1);
        #1;
        drive(1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        wait_idle(500, "arbitration");
    endtask

    task automatic test_back_to_back_dedup();
        int w;
        peak = 0;
        send(0, 2'd1, 2'd3, 2'd3, 2'd0, -1, w);
        send(0, 2'd1, 2'd3, 2'd3, 2'd0, -1, w);
        checks++;
        if (w != 0) begin
            errors++; $display("FAIL dedup_handshake: second handshake waited %0d cycles, required 0", w);
        end
        wait_idle(500, "dedup");
        checks++;
        if (peak != 1) begin
            errors++; $display("FAIL dedup_peak: fifo_count peak %0d, required 1", peak);
        end
        // msgtype 0 and SI with sino 0 complete but are dropped.
        send(0, 2'd0, 2'd1, 2'd1, 2'd1, -1, w);
        send(1, 2'd1, 2'd0, 2'd2, 2'd0, -1, w);
        repeat (4) @(negedge clk);
        checks++;
        if (fifo_count !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_invalid: count=%0d busy=%b, required 0/0", fifo_count, busy);
        end
    endtask

    task automatic test_fill_queue();
        int w, n;
        do_reset();
        stall = 1;
        send(1, 2'd3, 2'd0, 2'd0, 2'd0, -1, w);
        n = 0;
        while (n < 50 && !(busy && fifo_count == 0)) begin @(negedge clk); n++; end
        for (int f = 0; f < 4; f++) send(0, 2'd2, 2'd0, 2'd0, 2'(f), -1, w);
        drive(0, 1'b1, 2'd1, 2'd1, 2'd1, 2'd0);
        drive(1, 1'b1, 2'd1, 2'd2, 2'd2, 2'd0);
        #1;
        checks++;
        if ({r0_ready, r1_ready} !== 2'b00 || fifo_count !== 3'd4) begin
            errors++; $display("FAIL full_ready: ready r0r1=%b count=%0d, required 00 and 4",
                               {r0_ready, r1_ready}, fifo_count);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        drive(1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        stall = 0;
        wait_idle(2000, "fill");
    endtask

    task automatic test_timeout();
        int w, n;
        bit found;
        do_reset();
        stall_en = 1; stall_val = 8'h32;
        send(0, 2'd2, 2'd0, 2'd0, 2'd2, 3, w);
        send(1, 2'd3, 2'd0, 2'd0, 2'd0, -1, w);
        n = 0; found = 0;
        while (n < 300 && !found) begin
            @(negedge clk); n++;
            if (tx_start && tx_data == 8'h32) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL timeout_byte: farm digit byte not seen, required 1");
        end
        n = 0;
        while (n < TO + 20 && !err_timeout) begin @(negedge clk); n++; end
        checks++;
        if (n != TO + 1) begin
            errors++; $display("FAIL timeout_time: err_timeout after %0d cycles, required %0d", n, TO + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL timeout_idle: busy=%b after timeout, required 0", busy);
        end
        stall_en = 0;
        wait_idle(500, "timeout");
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL err_sticky: err_timeout=%b, required 1", err_timeout);
        end
    endtask

    task automatic test_async_reset();
        int w, n;
        stall = 1;
        send(0, 2'd1, 2'd2, 2'd1, 2'd0, -1, w);
        send(1, 2'd2, 2'd0, 2'd0, 2'd1, -1, w);
        n = 0;
        while (n < 50 && !tx_start) begin @(negedge clk); n++; end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_start, busy, fifo_count, err_timeout} !== 6'd0) begin
            errors++; $display("FAIL async_reset: start=%b busy=%b count=%0d err=%b, required all 0",
                               tx_start, busy, fifo_count, err_timeout);
        end
        sb.delete();
        last_t[0] = '0; last_t[1] = '0;
        stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 2'd1, 2'd2, 2'd1, 2'd0, -1, w);
        checks++;
        if (fifo_count !== 3'd1) begin
            errors++; $display("FAIL reset_repeat: count=%0d after repeat push, required 1", fifo_count);
        end
        wait_idle(500, "after_reset");
    endtask

    initial begin
        test_reset();
        test_single_si();
        test_arbitration();
        test_back_to_back_dedup();
        test_fill_queue();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
